// File: rtl/c5_pc_pkg.sv
// Shared definitions for the fetch PC sequencer: state encoding and default vectors.
package c5_pc_pkg;

    // Sequencer states, 2-bit registered encoding.
    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StRun      = 2'd1,
        StWait     = 2'd2,
        StExcFlush = 2'd3
    } pc_state_e;

    // Default byte addresses; bits [1:0] are ignored by the sequencer.
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_003C;

endpackage

// File: rtl/c5_increment.sv
// Word-address incrementer: value + 1 with silent wrap-around.
module c5_increment #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:2] value,
    output logic [WIDTH-1:2] value_inc
);

    // All-ones wraps to all-zeros; the carry out is deliberately dropped.
    assign value_inc = value + (WIDTH-2)'(1);

endmodule

// File: rtl/c5_pc_sequencer.sv
// Fetch PC sequencer: boots from the reset vector, advances on fetch handshakes,
// and accepts branch / exception redirects with exception taking priority.
module c5_pc_sequencer
    import c5_pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_stall,
    input  logic             I_branch,
    input  logic [WIDTH-1:2] I_branch_target,
    input  logic             I_exc,
    output logic             O_fetch_valid,
    input  logic             I_fetch_ready,
    output logic [WIDTH-1:2] O_pc,
    output logic [WIDTH-1:2] O_pc_next,
    output logic [WIDTH-1:2] O_epc,
    output logic             O_flush
);

    localparam logic [WIDTH-1:2] RESET_WORD = RESET_VECTOR[WIDTH-1:2];
    localparam logic [WIDTH-1:2] EXC_WORD   = EXC_VECTOR[WIDTH-1:2];

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:2] pc_q, pc_d;
    logic [WIDTH-1:2] epc_q, epc_d;
    logic [WIDTH-1:2] pc_inc;
    logic             fetch_valid;
    logic             flush;
    logic             branch_ok;

    c5_increment #(
        .WIDTH (WIDTH)
    ) u_increment (
        .value     (pc_q),
        .value_inc (pc_inc)
    );

    // A branch only counts when the pipeline is not paused.
    assign branch_ok = I_branch && !I_stall;

    // Next-state, next-PC and handshake/flush outputs from the current state and requests.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun, StWait: begin
                fetch_valid = 1'b1;
                if (I_exc) begin
                    // Exception wins even under stall; the return point is the branch
                    // target if that branch would itself have been taken this cycle.
                    flush   = 1'b1;
                    epc_d   = branch_ok ? I_branch_target : pc_q;
                    pc_d    = EXC_WORD;
                    state_d = StExcFlush;
                end else if (branch_ok) begin
                    // Abandons any pending, not-yet-accepted fetch.
                    flush   = 1'b1;
                    pc_d    = I_branch_target;
                    state_d = StRun;
                end else if (I_fetch_ready) begin
                    if (!I_stall) begin
                        pc_d = pc_inc;
                    end
                    state_d = StRun;
                end else begin
                    state_d = StWait;
                end
            end
            StExcFlush: begin
                // One bubble; redirect requests are ignored here.
                state_d = StRun;
            end
        endcase
    end

    // State, PC and EPC registers with asynchronous active-low reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_WORD;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    assign O_fetch_valid = fetch_valid;
    assign O_flush       = flush;
    assign O_pc          = pc_q;
    assign O_pc_next     = pc_inc;
    assign O_epc         = epc_q;

endmodule

// File: tb/tb_c5_pc_sequencer.sv
// Directed bench for c5_pc_sequencer with hand-computed expectations.
module tb_c5_pc_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             branch;
    logic [WIDTH-1:2] branch_target;
    logic             exc;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [WIDTH-1:2] pc;
    logic [WIDTH-1:2] pc_next;
    logic [WIDTH-1:2] epc;
    logic             flush;

    int n_checks;
    int n_fail;

    c5_pc_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .I_clk           (clk),
        .I_rst_n         (rst_n),
        .I_stall         (stall),
        .I_branch        (branch),
        .I_branch_target (branch_target),
        .I_exc           (exc),
        .O_fetch_valid   (fetch_valid),
        .I_fetch_ready   (fetch_ready),
        .O_pc            (pc),
        .O_pc_next       (pc_next),
        .O_epc           (epc),
        .O_flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values, then BOOT -> RUN and the first sequential fetches.
    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; exc = 1'b0;
        branch_target = '0; fetch_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== 30'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 30'h0); end
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
        n_checks++;
        if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
        n_checks++;
        if (epc !== 30'h0) begin n_fail++; $display("FAIL reset_epc got %h exp 0", epc); end
        rst_n = 1'b1;
        @(negedge clk);
        // After the first edge: RUN, fetch offered at the reset vector.
        n_checks++;
        if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL boot_to_run_valid got %b exp 1", fetch_valid); end
    endtask

    // ready held high: byte PCs 0x0, 0x4, 0x8, 0xC, then on to 0x10.
    task automatic test_sequential();
        logic [WIDTH-1:2] exp_pc [4];
        exp_pc[0] = 30'h0; exp_pc[1] = 30'h1; exp_pc[2] = 30'h2; exp_pc[3] = 30'h3;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pc !== exp_pc[i] || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_pc[%0d] got pc %h valid %b exp pc %h valid 1",
                         i, pc, fetch_valid, exp_pc[i]);
            end
            n_checks++;
            if (pc_next !== exp_pc[i] + 30'h1) begin
                n_fail++;
                $display("FAIL seq_pc_next[%0d] got %h exp %h", i, pc_next, exp_pc[i] + 30'h1);
            end
            @(negedge clk);
        end
        n_checks++;
        if (pc !== 30'h4) begin n_fail++; $display("FAIL seq_pc_0x10 got %h exp %h", pc, 30'h4); end
    endtask

    // ready low for 3 cycles at 0x10: PC and valid hold, then advance to 0x14.
    task automatic test_wait();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pc !== 30'h4 || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_hold[%0d] got pc %h valid %b exp pc %h valid 1",
                         i, pc, fetch_valid, 30'h4);
            end
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc !== 30'h5) begin n_fail++; $display("FAIL wait_release got %h exp %h", pc, 30'h5); end
    endtask

    // Branch to 0x200 held off by stall for 2 cycles, then taken with a single flush.
    task automatic test_branch_stall();
        logic [WIDTH-1:2] held;
        held = pc;
        branch = 1'b1; branch_target = 30'h80; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (flush !== 1'b0) begin n_fail++; $display("FAIL branch_stall_flush[%0d] got %b exp 0", i, flush); end
            @(negedge clk);
            n_checks++;
            if (pc !== held) begin n_fail++; $display("FAIL branch_stall_pc[%0d] got %h exp %h", i, pc, held); end
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b1) begin n_fail++; $display("FAIL branch_flush got %b exp 1", flush); end
        @(negedge clk);
        branch = 1'b0;
        #1;
        n_checks++;
        if (pc !== 30'h80 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_target got pc %h valid %b exp pc %h valid 1", pc, fetch_valid, 30'h80);
        end
        n_checks++;
        if (flush !== 1'b0) begin n_fail++; $display("FAIL branch_flush_once got %b exp 0", flush); end
        @(negedge clk);
    endtask

    // Exception and branch together: EPC takes the branch target, one bubble, then 0x3C.
    task automatic test_exception();
        exc = 1'b1; branch = 1'b1; branch_target = 30'hC0; stall = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush got %b exp 1", flush); end
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0 || pc !== 30'hF || epc !== 30'hC0) begin
            n_fail++;
            $display("FAIL exc_entry got valid %b pc %h epc %h exp valid 0 pc %h epc %h",
                     fetch_valid, pc, epc, 30'hF, 30'hC0);
        end
        // Redirects presented during the bubble must be ignored.
        branch_target = 30'h55;
        #1;
        n_checks++;
        if (flush !== 1'b0) begin n_fail++; $display("FAIL exc_flush_ignored got %b exp 0", flush); end
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b1 || pc !== 30'hF || epc !== 30'hC0) begin
            n_fail++;
            $display("FAIL exc_resume got valid %b pc %h epc %h exp valid 1 pc %h epc %h",
                     fetch_valid, pc, epc, 30'hF, 30'hC0);
        end
        exc = 1'b0; branch = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc !== 30'h10) begin n_fail++; $display("FAIL exc_advance got %h exp %h", pc, 30'h10); end
        // Exception under stall: EPC must be the current PC, not the branch target.
        exc = 1'b1; branch = 1'b1; branch_target = 30'h99; stall = 1'b1;
        @(negedge clk);
        exc = 1'b0; branch = 1'b0; stall = 1'b0;
        n_checks++;
        if (epc !== 30'h10 || pc !== 30'hF) begin
            n_fail++;
            $display("FAIL exc_stall_epc got epc %h pc %h exp epc %h pc %h", epc, pc, 30'h10, 30'hF);
        end
        @(negedge clk);
    endtask

    // Wrap from 0xFFFF_FFFC to 0x0, then asynchronous reset mid-WAIT.
    task automatic test_wrap_and_reset();
        branch = 1'b1; branch_target = '1;
        @(negedge clk);
        branch = 1'b0;
        n_checks++;
        if (pc !== 30'h3FFF_FFFF || pc_next !== 30'h0) begin
            n_fail++;
            $display("FAIL wrap_pc_next got pc %h next %h exp pc %h next 0", pc, pc_next, 30'h3FFF_FFFF);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 30'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", pc); end
        @(negedge clk);
        fetch_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc !== 30'h1 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_wait got pc %h valid %b exp pc 1 valid 1", pc, fetch_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pc !== 30'h0 || fetch_valid !== 1'b0 || epc !== 30'h0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got pc %h valid %b epc %h flush %b exp 0 0 0 0",
                     pc, fetch_valid, epc, flush);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc !== 30'h0 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_boot got pc %h valid %b exp pc 0 valid 1", pc, fetch_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequential();
        test_wait();
        test_branch_stall();
        test_exception();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c5_pc_sequencer.md
C5_PC_SEQUENCER -- requirements
Module: c5_pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address width; the PC is held as word address bits [WIDTH-1:2].
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the byte address of the first fetch; bits [1:0] are ignored.
REQ-003 The block SHALL have parameter EXC_VECTOR, default 32'h0000_003C, giving the byte address of the exception entry; bits [1:0] are ignored.
REQ-004 The block SHALL have port I_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port I_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port I_stall, input, 1 bit: pipeline pause; freezes sequential advance and branch acceptance.
REQ-007 The block SHALL have ports I_branch (input, 1 bit) and I_branch_target (input, [WIDTH-1:2]): a redirect request and its word target.
REQ-008 The block SHALL have port I_exc, input, 1 bit: exception/interrupt request.
REQ-009 The block SHALL have ports O_fetch_valid (output, 1 bit) and I_fetch_ready (input, 1 bit): the fetch handshake; transfer occurs when both are 1.
REQ-010 The block SHALL have ports O_pc (output, [WIDTH-1:2]), the current fetch word address, and O_pc_next (output, [WIDTH-1:2]), equal to O_pc+1 with wrap-around.
REQ-011 The block SHALL have port O_epc, output, [WIDTH-1:2]: the saved exception return address.
REQ-012 The block SHALL have port O_flush, output, 1 bit: a one-cycle pulse on every accepted redirect (branch or exception).

Function
REQ-013 The block SHALL implement states BOOT, RUN, WAIT and EXC_FLUSH, registered.
REQ-014 In BOOT, O_fetch_valid SHALL be 0 and the next state SHALL be RUN unconditionally.
REQ-015 In RUN and WAIT, O_fetch_valid SHALL be 1; with no redirect, a cycle with fetch_valid&!I_fetch_ready SHALL go to or stay in WAIT with O_pc unchanged.
REQ-016 On transfer (valid&ready) with I_stall=0 and no redirect, O_pc SHALL load O_pc_next and the state SHALL be RUN; with I_stall=1, O_pc SHALL hold.
REQ-017 Redirect priority SHALL be I_exc > I_branch > sequential, evaluated in RUN and WAIT only.
REQ-018 I_branch SHALL be accepted only when I_stall=0; then O_pc<=I_branch_target, O_flush=1, state RUN, and any unaccepted fetch is abandoned (sole exception to valid-hold).
REQ-019 I_exc SHALL be accepted regardless of I_stall; then O_epc<=I_branch_target if I_branch=1 that cycle and I_stall=0, else O_pc; O_pc<=EXC_VECTOR[WIDTH-1:2]; O_flush=1; state EXC_FLUSH.
REQ-020 In EXC_FLUSH, O_fetch_valid SHALL be 0, I_exc and I_branch SHALL be ignored, and the next state SHALL be RUN.
REQ-021 The increment SHALL wrap: O_pc all-ones SHALL give O_pc_next all-zeros with no flag.
REQ-022 Redirect acceptance SHALL cost zero bubbles for a branch and exactly one bubble (EXC_FLUSH) for an exception; fetch of the new O_pc is offered the next cycle.
REQ-023 O_flush SHALL be combinational from the current-cycle acceptance condition; all other outputs SHALL be registered or derived from registered state.

Reset
REQ-024 While I_rst_n=0, the block SHALL asynchronously force state BOOT, O_pc=RESET_VECTOR[WIDTH-1:2], O_epc=0, O_fetch_valid=0, O_flush=0; mid-transfer and mid-EXC_FLUSH reset SHALL discard all pending activity.
REQ-025 Reset release SHALL be synchronous-deasserted externally; the first fetch SHALL be offered on the second rising edge after release (BOOT then RUN).

Structure
REQ-026 State encodings (2 bits) and default vector constants SHALL live in a shared package c5_pc_pkg.
REQ-027 The +1 word increment SHALL be a single instance of c5_increment with matching WIDTH; no other sub-module.

Verification
REQ-028 Reset, then ready=1 held, no stall -> O_pc sequence (byte) 0x0,0x4,0x8,0xC, fetch_valid low only during BOOT.
REQ-029 ready=0 for 3 cycles at O_pc=0x10 -> O_pc held 0x10, state WAIT, valid held 1; then ready=1 -> O_pc 0x14.
REQ-030 I_branch=1, target byte 0x200, I_stall=1 for 2 cycles then 0 -> no redirect while stalled; O_flush pulses once, next O_pc 0x200.
REQ-031 I_exc=1 and I_branch=1 (target 0x300) same cycle, no stall -> O_epc 0x300, one invalid cycle, O_pc 0x3C; I_exc during EXC_FLUSH ignored.
REQ-032 O_pc byte 0xFFFF_FFFC, transfer -> O_pc 0x0; assert I_rst_n=0 mid-WAIT -> immediate O_pc 0x0, valid 0.
